// File: rtl/rob_commit.sv
// In-order reorder buffer with single-wide commit.
// Retirement drives the physical-register free and flag-write ports.
module rob_commit #(
    parameter int ROB_DEPTH    = 8,
    parameter int NUM_FU       = 4,
    parameter int NUM_PHYS_REG = 128,
    parameter int NUM_FLAGS    = 4,
    localparam int IW = $clog2(ROB_DEPTH),
    localparam int PW = $clog2(NUM_PHYS_REG),
    localparam int FW = 2 * NUM_FLAGS,
    localparam int CW = IW + 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           disp_v_i,
    output logic                           disp_ready_o,
    input  logic                           disp_has_dest_i,
    input  logic [PW-1:0]                  disp_old_phys_i,
    input  logic                           disp_flag_v_i,
    output logic [IW-1:0]                  disp_rob_idx_o,
    input  logic [NUM_FU-1:0]              exe_done_v_i,
    input  logic [NUM_FU-1:0][IW-1:0]      exe_rob_idx_i,
    input  logic [NUM_FU-1:0][FW-1:0]      exe_flag_i,
    input  logic                           flush_i,
    output logic                           rob_phys_valid_o,
    output logic [PW-1:0]                  rob_phys_reg_cl_o,
    output logic                           rob_flag_valid_o,
    output logic [FW-1:0]                  rob_flag_o,
    output logic                           commit_v_o,
    output logic [CW-1:0]                  count_o,
    output logic [31:0]                    retire_cnt_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(ROB_DEPTH);

    logic [IW-1:0]                 head_q, head_d;
    logic [IW-1:0]                 tail_q, tail_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [31:0]                   retire_cnt_q, retire_cnt_d;
    logic [ROB_DEPTH-1:0]          busy_q, busy_d;
    logic [ROB_DEPTH-1:0]          done_q, done_d;
    logic [ROB_DEPTH-1:0]          has_dest_q, has_dest_d;
    logic [ROB_DEPTH-1:0]          flag_v_q, flag_v_d;
    logic [ROB_DEPTH-1:0][PW-1:0]  old_phys_q, old_phys_d;
    logic [ROB_DEPTH-1:0][FW-1:0]  flag_q, flag_d;

    logic accept;
    logic commit;

    assign disp_ready_o   = (count_q < DEPTH_C);
    assign disp_rob_idx_o = tail_q;
    assign accept         = disp_v_i & disp_ready_o & ~flush_i;
    assign commit         = busy_q[head_q] & done_q[head_q] & ~flush_i;

    assign commit_v_o        = commit;
    assign rob_phys_valid_o  = commit & has_dest_q[head_q];
    assign rob_phys_reg_cl_o = rob_phys_valid_o ? old_phys_q[head_q] : '0;
    assign rob_flag_valid_o  = commit & flag_v_q[head_q];
    assign rob_flag_o        = rob_flag_valid_o ? flag_q[head_q] : '0;
    assign count_o           = count_q;
    assign retire_cnt_o      = retire_cnt_q;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        has_dest_d   = has_dest_q;
        flag_v_d     = flag_v_q;
        old_phys_d   = old_phys_q;
        flag_d       = flag_q;

        // Descending scan so the lowest-numbered FU writes last and wins.
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (exe_done_v_i[i] && busy_q[exe_rob_idx_i[i]]) begin
                done_d[exe_rob_idx_i[i]] = 1'b1;
                flag_d[exe_rob_idx_i[i]] = exe_flag_i[i];
            end
        end

        if (accept) begin
            busy_d[tail_q]     = 1'b1;
            done_d[tail_q]     = 1'b0;
            has_dest_d[tail_q] = disp_has_dest_i;
            old_phys_d[tail_q] = disp_old_phys_i;
            flag_v_d[tail_q]   = disp_flag_v_i;
            tail_d             = tail_q + 1'b1;
        end

        if (commit) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
            retire_cnt_d   = retire_cnt_q + 32'd1;
        end

        unique case ({accept, commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
            busy_q       <= '0;
            done_q       <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Payload fields are only observed behind busy/done, so they need no reset.
    always_ff @(posedge clk_i) begin
        has_dest_q <= has_dest_d;
        flag_v_q   <= flag_v_d;
        old_phys_q <= old_phys_d;
        flag_q     <= flag_d;
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed vector bench for rob_commit: per-cycle table plus a
// pipelined dispatch/complete/commit sequence across pointer wrap.
module tb_rob_commit;

    logic        clk;
    logic        reset_i;
    logic        disp_v_i;
    logic        disp_ready_o;
    logic        disp_has_dest_i;
    logic [6:0]  disp_old_phys_i;
    logic        disp_flag_v_i;
    logic [2:0]  disp_rob_idx_o;
    logic [3:0]  exe_done_v_i;
    logic [11:0] exe_rob_idx_i;
    logic [31:0] exe_flag_i;
    logic        flush_i;
    logic        rob_phys_valid_o;
    logic [6:0]  rob_phys_reg_cl_o;
    logic        rob_flag_valid_o;
    logic [7:0]  rob_flag_o;
    logic        commit_v_o;
    logic [3:0]  count_o;
    logic [31:0] retire_cnt_o;

    int total = 0;
    int bad   = 0;

    rob_commit dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .disp_v_i          (disp_v_i),
        .disp_ready_o      (disp_ready_o),
        .disp_has_dest_i   (disp_has_dest_i),
        .disp_old_phys_i   (disp_old_phys_i),
        .disp_flag_v_i     (disp_flag_v_i),
        .disp_rob_idx_o    (disp_rob_idx_o),
        .exe_done_v_i      (exe_done_v_i),
        .exe_rob_idx_i     (exe_rob_idx_i),
        .exe_flag_i        (exe_flag_i),
        .flush_i           (flush_i),
        .rob_phys_valid_o  (rob_phys_valid_o),
        .rob_phys_reg_cl_o (rob_phys_reg_cl_o),
        .rob_flag_valid_o  (rob_flag_valid_o),
        .rob_flag_o        (rob_flag_o),
        .commit_v_o        (commit_v_o),
        .count_o           (count_o),
        .retire_cnt_o      (retire_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, dv, dhd;
        logic [6:0]  dold;
        logic        dfv;
        logic [3:0]  ev;
        logic [11:0] eidx;
        logic [31:0] eflag;
        logic        fl;
        logic        rdy;
        logic [2:0]  idx;
        logic        cv, pv;
        logic [6:0]  preg;
        logic        fv;
        logic [7:0]  flg;
        logic [3:0]  cnt;
        logic [31:0] rc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t V(
        input logic rst, dv, dhd, input logic [6:0] dold, input logic dfv,
        input logic [3:0] ev, input logic [11:0] eidx, input logic [31:0] eflag,
        input logic fl, input logic rdy, input logic [2:0] idx,
        input logic cv, pv, input logic [6:0] preg, input logic fv,
        input logic [7:0] flg, input logic [3:0] cnt, input logic [31:0] rc);
        vec_t t;
        t.rst = rst; t.dv = dv; t.dhd = dhd; t.dold = dold; t.dfv = dfv;
        t.ev = ev; t.eidx = eidx; t.eflag = eflag; t.fl = fl;
        t.rdy = rdy; t.idx = idx; t.cv = cv; t.pv = pv; t.preg = preg;
        t.fv = fv; t.flg = flg; t.cnt = cnt; t.rc = rc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        reset_i = 0; disp_v_i = 0; disp_has_dest_i = 0; disp_old_phys_i = 0;
        disp_flag_v_i = 0; exe_done_v_i = 0; exe_rob_idx_i = 0;
        exe_flag_i = 0; flush_i = 0;
    endtask

    initial begin
        logic [11:0] ei;
        logic [31:0] ef;
        int f;

        // Inputs per cycle, then outputs expected before that cycle's edge.
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,0,0,0,0,0,8'h00,0,0));
        vq.push_back(V(0,1,1,20,0, 4'h0,12'h0,32'h0,0, 1,0,0,0,0,0,8'h00,0,0));
        vq.push_back(V(0,0,0,0,0, 4'h1,12'h0,32'h0,0, 1,1,0,0,0,0,8'h00,1,0));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,1,1,20,0,8'h00,1,0));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,0,0,0,0,8'h00,0,1));
        vq.push_back(V(1,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,0,0,0,0,8'h00,0,1));
        for (int k = 0; k < 8; k++)
            vq.push_back(V(0,1,1,7'(40+k),logic'(k==4), 4'h0,12'h0,32'h0,0,
                           1,3'(k),0,0,0,0,8'h00,4'(k),0));
        vq.push_back(V(0,1,1,50,0, 4'h0,12'h0,32'h0,0, 0,0,0,0,0,0,8'h00,8,0));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 0,0,0,0,0,0,8'h00,8,0));
        vq.push_back(V(0,0,0,0,0, 4'h1,{3'd0,3'd0,3'd0,3'd2},32'h0,0,
                       0,0,0,0,0,0,8'h00,8,0));
        vq.push_back(V(0,0,0,0,0, 4'h4,{3'd0,3'd0,3'd0,3'd0},{8'h00,8'hFF,8'h00,8'h00},0,
                       0,0,0,0,0,0,8'h00,8,0));
        vq.push_back(V(0,1,1,77,0, 4'h2,{3'd0,3'd0,3'd1,3'd0},32'h0,0,
                       0,0,1,1,40,0,8'h00,8,0));
        vq.push_back(V(0,1,1,99,0, 4'h0,12'h0,32'h0,0, 1,0,1,1,41,0,8'h00,7,1));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,1,1,42,0,8'h00,7,2));
        vq.push_back(V(0,0,0,0,0, 4'hB,{3'd4,3'd0,3'd4,3'd3},{8'h0F,8'h00,8'h34,8'h00},0,
                       1,1,0,0,0,0,8'h00,6,3));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,1,1,43,0,8'h00,6,3));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,1,1,44,1,8'h34,5,4));
        vq.push_back(V(0,1,0,7,1, 4'h0,12'h0,32'h0,0, 1,1,0,0,0,0,8'h00,4,5));
        vq.push_back(V(0,0,0,0,0, 4'h4,{3'd0,3'd5,3'd0,3'd0},32'h0,0,
                       1,2,0,0,0,0,8'h00,5,5));
        vq.push_back(V(0,1,1,9,0, 4'h1,{3'd0,3'd0,3'd0,3'd6},32'h0,1,
                       1,2,0,0,0,0,8'h00,5,5));
        vq.push_back(V(0,0,0,0,0, 4'h3,{3'd0,3'd0,3'd0,3'd3},32'h0,0,
                       1,0,0,0,0,0,8'h00,0,5));
        vq.push_back(V(0,1,1,11,1, 4'h0,12'h0,32'h0,0, 1,0,0,0,0,0,8'h00,0,5));
        vq.push_back(V(0,0,0,0,0, 4'h8,{3'd0,3'd0,3'd0,3'd0},{8'hA5,8'h00,8'h00,8'h00},0,
                       1,1,0,0,0,0,8'h00,1,5));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,1,1,11,1,8'hA5,1,5));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,0,0,0,0,8'h00,0,6));
        vq.push_back(V(0,1,0,0,0, 4'h0,12'h0,32'h0,0, 1,1,0,0,0,0,8'h00,0,6));
        vq.push_back(V(1,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,2,0,0,0,0,8'h00,1,6));
        vq.push_back(V(0,0,0,0,0, 4'h0,12'h0,32'h0,0, 1,0,0,0,0,0,8'h00,0,0));

        drive_idle();
        reset_i = 1;
        repeat (2) @(posedge clk);

        foreach (vq[n]) begin
            @(negedge clk);
            reset_i         = vq[n].rst;
            disp_v_i        = vq[n].dv;
            disp_has_dest_i = vq[n].dhd;
            disp_old_phys_i = vq[n].dold;
            disp_flag_v_i   = vq[n].dfv;
            exe_done_v_i    = vq[n].ev;
            exe_rob_idx_i   = vq[n].eidx;
            exe_flag_i      = vq[n].eflag;
            flush_i         = vq[n].fl;
            #1;
            chk($sformatf("v%0d ready", n), 32'(disp_ready_o), 32'(vq[n].rdy));
            chk($sformatf("v%0d idx", n), 32'(disp_rob_idx_o), 32'(vq[n].idx));
            chk($sformatf("v%0d commit", n), 32'(commit_v_o), 32'(vq[n].cv));
            chk($sformatf("v%0d phys_v", n), 32'(rob_phys_valid_o), 32'(vq[n].pv));
            chk($sformatf("v%0d phys", n), 32'(rob_phys_reg_cl_o), 32'(vq[n].preg));
            chk($sformatf("v%0d flag_v", n), 32'(rob_flag_valid_o), 32'(vq[n].fv));
            chk($sformatf("v%0d flag", n), 32'(rob_flag_o), 32'(vq[n].flg));
            chk($sformatf("v%0d count", n), 32'(count_o), 32'(vq[n].cnt));
            chk($sformatf("v%0d retired", n), retire_cnt_o, vq[n].rc);
        end

        // Serial dispatch/complete/commit through two pointer wraps.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            drive_idle();
            disp_v_i        = 1;
            disp_has_dest_i = 1;
            disp_old_phys_i = 7'(n + 1);
            disp_flag_v_i   = logic'(n % 2);
            #1;
            chk($sformatf("s%0d idx", n), 32'(disp_rob_idx_o), 32'(n % 8));
            chk($sformatf("s%0d ready", n), 32'(disp_ready_o), 32'd1);

            @(negedge clk);
            drive_idle();
            f  = n % 4;
            ei = '0;
            ef = '0;
            ei[3*f +: 3] = 3'(n % 8);
            ef[8*f +: 8] = 8'(n);
            exe_done_v_i  = 4'(1 << f);
            exe_rob_idx_i = ei;
            exe_flag_i    = ef;
            #1;
            chk($sformatf("s%0d early", n), 32'(commit_v_o), 32'd0);

            @(negedge clk);
            drive_idle();
            #1;
            chk($sformatf("s%0d commit", n), 32'(commit_v_o), 32'd1);
            chk($sformatf("s%0d phys", n), 32'(rob_phys_reg_cl_o), 32'(n + 1));
            chk($sformatf("s%0d flag_v", n), 32'(rob_flag_valid_o), 32'(n % 2));
            chk($sformatf("s%0d flag", n), 32'(rob_flag_o), (n % 2) ? 32'(n) : 32'd0);
        end

        @(negedge clk);
        drive_idle();
        #1;
        chk("seq retired", retire_cnt_o, 32'd20);
        chk("seq count", 32'(count_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
In-order reorder buffer and commit stage that sits directly upstream of the physical register/flag state block. It allocates one entry per dispatched instruction and records completions from the functional units. It retires at most one instruction per cycle, in program order. On retire it drives the physical-register free (clear) and flag-write interfaces of the register/flag state block.

Parameters:
ROB_DEPTH, 8, number of entries; power of two, minimum 2
NUM_FU, 4, number of functional-unit completion ports
NUM_PHYS_REG, 128, physical registers; tag width is $clog2(NUM_PHYS_REG)
NUM_FLAGS, 4, architectural flag bits

Ports:
clk_i  in  1  clock; all state updates on posedge
reset_i  in  1  synchronous reset, active-high
disp_v_i  in  1  dispatch request; accepted when disp_v_i & disp_ready_o
disp_ready_o  out  1  buffer not full (count < ROB_DEPTH)
disp_has_dest_i  in  1  instruction overwrites an architectural register
disp_old_phys_i  in  $clog2(NUM_PHYS_REG)  previous physical mapping, freed at commit
disp_flag_v_i  in  1  instruction writes flags
disp_rob_idx_o  out  $clog2(ROB_DEPTH)  tail index given to the dispatched instruction
exe_done_v_i  in  NUM_FU  per-FU completion strobe
exe_rob_idx_i  in  NUM_FU x $clog2(ROB_DEPTH)  completing entry index
exe_flag_i  in  NUM_FU x 2*NUM_FLAGS  {mask, value}; mask bit 1 = keep old flag
flush_i  in  1  discard all entries
rob_phys_valid_o  out  1  free one physical register this cycle
rob_phys_reg_cl_o  out  $clog2(NUM_PHYS_REG)  physical register to free
rob_flag_valid_o  out  1  flag write this cycle
rob_flag_o  out  2*NUM_FLAGS  {mask, value} forwarded unchanged from the entry
commit_v_o  out  1  head retired this cycle
count_o  out  $clog2(ROB_DEPTH)+1  occupied entries
retire_cnt_o  out  32  total retired instructions, wraps modulo 2^32

Behaviour:
- State: head and tail pointers (wrap modulo ROB_DEPTH), count, and per-entry fields: busy, done, has_dest, old_phys, flag_v, flag.
- Reset (synchronous): head=tail=0, count=0, all busy/done=0, retire_cnt=0.
- Outputs after reset: disp_ready_o=1, disp_rob_idx_o=0, commit_v_o=0, rob_phys_valid_o=0, rob_flag_valid_o=0, count_o=0, retire_cnt_o=0. rob_phys_reg_cl_o and rob_flag_o are 0 while their valids are 0.
- Dispatch:
  - disp_ready_o = (count < ROB_DEPTH), taken from the registered count only. A commit in the same cycle does not open a slot when the buffer is full.
  - On accept: entry[tail] gets busy=1, done=0 and the dispatch fields; tail increments.
  - disp_rob_idx_o equals tail combinationally.
- Completion:
  - For each i with exe_done_v_i[i] and entry[exe_rob_idx_i[i]].busy: set done=1 and capture the flag field.
  - Completion to a non-busy entry is ignored.
  - If several FUs name the same entry in one cycle, the lowest-numbered FU's flag value wins.
  - done becomes visible the next cycle, so minimum dispatch-to-commit latency is 2 cycles.
- Commit:
  - commit_v_o = entry[head].busy & entry[head].done & ~flush_i, combinational from registered state.
  - When commit_v_o=1:
    - rob_phys_valid_o = has_dest, rob_phys_reg_cl_o = old_phys.
    - rob_flag_valid_o = flag_v, rob_flag_o = entry flag.
  - At the clock edge: busy[head] cleared, head increments, retire_cnt increments.
  - At most one commit per cycle.
- Count: next = count + accept − commit. Simultaneous accept and commit leaves count unchanged. An empty buffer never commits.
- Flush:
  - Takes priority over dispatch, completion and commit in the same cycle.
  - Next state: all busy/done=0, head=tail=0, count=0; retire_cnt unchanged.
  - In the flush cycle: commit_v_o=0 and all rob_*_valid_o=0; disp_ready_o still reflects current count, but an accept in that cycle is discarded.
- reset_i asserted mid-operation drops all in-flight entries exactly like reset; there is no partial commit.
- Pointer wrap: index ROB_DEPTH-1 is followed by index 0. Full when count==ROB_DEPTH (head==tail); empty when count==0.

Test Plan:
- Reset, then dispatch 1 entry (has_dest=1, old_phys=20, flag_v=0); 1 cycle later complete FU0 idx 0 -> next cycle commit_v_o=1, rob_phys_valid_o=1, rob_phys_reg_cl_o=20, rob_flag_valid_o=0, retire_cnt_o=1.
- Dispatch 8 entries with no completions -> count_o=8, disp_ready_o=0; a 9th disp_v_i is not accepted and tail stays at 0.
- Complete idx 2 then idx 0 then idx 1 -> commits occur in order 0,1,2 on consecutive cycles; nothing commits while only idx 2 is done.
- Full buffer with head done, disp_v_i=1 in the same cycle -> commit occurs, dispatch is not accepted, count_o=7; the next cycle's dispatch is accepted into idx 0 (wrap).
- FU1 and FU3 both complete idx 4 with flags {mask=4'b0011, val=4'b0100} and {4'b0000, 4'b1111}; entry has flag_v=1 -> at commit rob_flag_valid_o=1, rob_flag_o=8'b0011_0100.
- 5 entries pending, head done, flush_i=1 -> commit_v_o=0 that cycle; next cycle count_o=0, disp_rob_idx_o=0; a later completion to old idx 3 is ignored.
